// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings as presented on the op port
//   - FSM state encodings
//   - default operand width
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide loop on unsigned magnitudes.
// Ports:
//   acc      in   2*WIDTH  working accumulator
//                          multiply: {partial product, remaining multiplier bits}
//                          divide:   {partial remainder, remaining dividend / quotient bits}
//   operand  in   WIDTH    multiplicand (multiply) or divisor (divide)
//   is_div   in   1        select restoring-divide step instead of shift-add
//   acc_next out  2*WIDTH  accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic               take;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Shift-add: the carry out of the upper half becomes the new top bit after the shift.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    mul_next = {sum, acc[WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs WIDTH+1 bits before the compare.
    // When the subtract is taken the difference is below the divisor, so WIDTH bits suffice.
    trial    = acc[2*WIDTH-1:WIDTH-1];
    take     = (trial >= {1'b0, operand});
    div_next = take ? {trial[WIDTH-1:0] - operand, acc[WIDTH-2:0], 1'b1}
                    : {trial[WIDTH-1:0],           acc[WIDTH-2:0], 1'b0};

    acc_next = is_div ? div_next : mul_next;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at start, iterated WIDTH times through
// muldiv_step, then sign-corrected in FIXUP before landing in HI/LO.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      begin an operation (accepted in IDLE or DONE only)
//   op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  in   WIDTH  operand A (multiplicand / dividend); MTHI/MTLO source
//   rt_data  in   WIDTH  operand B (multiplier / divisor)
//   hi_we    in   1      MTHI write strobe
//   lo_we    in   1      MTLO write strobe
//   busy     out  1      operation in flight (RUN or FIXUP)
//   done     out  1      single-cycle completion pulse
//   hi       out  WIDTH  HI register (product upper half / remainder)
//   lo       out  WIDTH  LO register (product lower half / quotient)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   rs_orig_q, rs_orig_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;   // negate product / quotient
  logic               neg_hi_q, neg_hi_d;   // remainder follows dividend sign
  logic               div0_q, div0_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               can_accept;
  logic               accept;
  logic               last_iter;
  logic               op_signed;
  logic               op_div;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (is_div_q),
    .acc_next (step_acc)
  );

  assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept     = can_accept && start;
  assign last_iter  = (cnt_q == CW'(WIDTH-1));

  // Next-state / counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d   = '0;
        state_d = start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (last_iter) begin
          state_d = S_FIXUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIXUP: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_comb begin
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    sa        = op_signed && rs_data[WIDTH-1];
    sb        = op_signed && rt_data[WIDTH-1];
    abs_a     = cond_neg_w(rs_data, sa);
    abs_b     = cond_neg_w(rt_data, sb);

    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rs_orig_d = rs_orig_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;

    if (accept) begin
      rs_orig_d = rs_data;
      is_div_d  = op_div;
      neg_lo_d  = sa ^ sb;
      neg_hi_d  = op_div && sa;
      div0_d    = op_div && (rt_data == '0);
      if (op_div) begin
        acc_d  = {{WIDTH{1'b0}}, abs_a};
        opnd_d = abs_b;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, abs_b};
        opnd_d = abs_a;
      end
    end else if (state_q == S_RUN) begin
      acc_d = step_acc;
    end
  end

  // HI/LO update: FIXUP result, or MTHI/MTLO when idle and no start competes
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    prod = cond_neg_2w(acc_q, neg_lo_q);
    if (state_q == S_FIXUP) begin
      if (is_div_q && div0_q) begin
        lo_d = '1;
        hi_d = rs_orig_q;
      end else if (is_div_q) begin
        lo_d = cond_neg_w(acc_q[WIDTH-1:0], neg_lo_q);
        hi_d = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
      end else begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
      end
    end else if (can_accept && !start) begin
      if (hi_we) hi_d = rs_data;
      if (lo_we) lo_d = rs_data;
    end
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath registers; only meaningful after a start, so no reset
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    rs_orig_q <= rs_orig_d;
    is_div_q  <= is_div_d;
    neg_lo_q  <= neg_lo_d;
    neg_hi_q  <= neg_hi_d;
    div0_q    <= div0_d;
  end

  assign busy = (state_q == S_RUN) || (state_q == S_FIXUP);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total  = 0;
  int passed = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
  endtask

  // Advances until done is seen, with a bounded cycle budget.
  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_cnt;

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi",   hi, 32'h0);
    chk("reset_lo",   lo, 32'h0);

    // 1. MULTU max*max, with busy duration and done placement
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("multu_busy_cycles", n, 32'd33);
    chk("multu_done",        {31'b0, done}, 32'd1);
    chk("multu_hi",          hi, 32'hFFFF_FFFE);
    chk("multu_lo",          lo, 32'h0000_0001);
    tick();
    chk("multu_done_pulse",  {31'b0, done}, 32'd0);

    // 2. MULT -3*7, then DIV -7/2 launched from the DONE cycle
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_done");
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done("div_done");
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // 3. Divide by zero and signed overflow
    start_op(2'b11, 32'd5, 32'd0);
    wait_done("divu0_done");
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd5);
    start_op(2'b10, 32'hFFFF_FFFB, 32'd0);
    wait_done("div0_done");
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFFB);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf_done");
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // 4. start and hi_we while busy are ignored
    start_op(2'b01, 32'd6, 32'd7);
    tick(); tick(); tick();
    start = 1'b1; op = 2'b10; rs_data = 32'd1; rt_data = 32'd1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", {31'b0, busy}, 32'd1);
    tick(); tick(); tick(); tick();
    hi_we = 1'b1; rs_data = 32'hABCD;
    tick();
    hi_we = 1'b0;
    chk("busy_hiwe_ignored", hi, 32'h0);
    wait_done("mul42_done");
    chk("mul42_hi", hi, 32'h0);
    chk("mul42_lo", lo, 32'd42);

    // 5. MTHI in IDLE; start beats lo_we in the same cycle
    tick();
    hi_we = 1'b1; rs_data = 32'h1234;
    tick();
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'd42);
    lo_we = 1'b1;
    start_op(2'b01, 32'd2, 32'd3);
    lo_we = 1'b0;
    chk("lowe_dropped_lo",   lo, 32'd42);
    chk("lowe_dropped_busy", {31'b0, busy}, 32'd1);
    wait_done("mul6_done");
    chk("mul6_lo", lo, 32'd6);
    chk("mul6_hi", hi, 32'd0);

    // 6. Reset in the middle of a DIVU, then a clean rerun
    tick();
    start_op(2'b11, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi",   hi, 32'h0);
    chk("midrst_lo",   lo, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    chk("midrst_no_done", done_cnt, 32'd0);
    start_op(2'b11, 32'd100, 32'd7);
    wait_done("rerun_done");
    chk("rerun_lo", lo, 32'd14);
    chk("rerun_hi", hi, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
